// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, FSM states and the default width.
package exec_pkg;

    localparam int W_DEFAULT = 8;

    // Opcodes 10-15 are all treated as NOP; OP_NOP names the first of them.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_PASS = 4'd7,
        OP_MUL  = 4'd8,
        OP_MULH = 4'd9,
        OP_NOP  = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_WB_MUL = 2'd2
    } state_e;

    // Multi-cycle ops go through the shift-add multiplier.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    // Single-cycle ops write back on the cycle after accept.
    function automatic logic is_single_op(input logic [3:0] op);
        return op <= OP_PASS;
    endfunction

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier: one partial-product bit per cycle.
// start latches the operands; done flags the cycle of the last iteration,
// with product showing the value the accumulator takes at that edge.
module exec_mul #(
    parameter int W          = 8,
    parameter int MUL_CYCLES = W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES) + 1;

    logic           busy_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        product = acc_d;
        done    = busy_q && (cnt_q == CW'(MUL_CYCLES - 1));
    end

    // Operand capture on start, then one iteration per cycle until the count runs out.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_alu.sv
// Execute stage: single-cycle ALU plus an FSM that sequences the
// multi-cycle multiplier and drives the register-file write port.
module exec_alu
    import exec_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int MUL_CYCLES = W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic [2:0]   rd,
    output logic         wb_rw,
    output logic [2:0]   wb_rd,
    output logic [W-1:0] wb_data,
    output logic         flag_z,
    output logic         flag_c
);

    state_e         state_q, state_d;
    logic           mulh_q, mulh_d;
    logic [2:0]     mul_rd_q, mul_rd_d;
    logic           wb_rw_q;
    logic [2:0]     wb_rd_q;
    logic [W-1:0]   wb_data_q;
    logic           flag_z_q, flag_c_q;

    logic [W:0]     sum;
    logic [W-1:0]   alu_res;
    logic           alu_c;

    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    logic           wr_en;
    logic [2:0]     wr_rd;
    logic [W-1:0]   wr_data;
    logic           wr_c;

    exec_mul #(
        .W          (W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (rs_val),
        .b       (rt_val),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign wb_rw    = wb_rw_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

    // Single-cycle datapath; carry is bit W of the unsigned W+1-bit add/sub.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum     = {1'b0, rs_val} + {1'b0, rt_val};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            OP_SUB: begin
                sum     = {1'b0, rs_val} - {1'b0, rt_val};
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            OP_AND:  alu_res = rs_val & rt_val;
            OP_OR:   alu_res = rs_val | rt_val;
            OP_XOR:  alu_res = rs_val ^ rt_val;
            OP_SLL:  alu_res = rs_val << rt_val[2:0];
            OP_SRL:  alu_res = rs_val >> rt_val[2:0];
            OP_PASS: alu_res = rs_val;
            default: alu_res = '0;
        endcase
    end

    // FSM next state and write-back request; rd = 0 and NOPs use their slot but never write.
    always_comb begin
        state_d   = state_q;
        mulh_d    = mulh_q;
        mul_rd_d  = mul_rd_q;
        mul_start = 1'b0;
        wr_en     = 1'b0;
        wr_rd     = wb_rd_q;
        wr_data   = wb_data_q;
        wr_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(op)) begin
                        mul_start = 1'b1;
                        mulh_d    = (op == OP_MULH);
                        mul_rd_d  = rd;
                        state_d   = ST_MUL;
                    end else if (is_single_op(op) && (rd != 3'd0)) begin
                        wr_en   = 1'b1;
                        wr_rd   = rd;
                        wr_data = alu_res;
                        wr_c    = alu_c;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_WB_MUL;
                    if (mul_rd_q != 3'd0) begin
                        wr_en   = 1'b1;
                        wr_rd   = mul_rd_q;
                        wr_data = mulh_q ? mul_product[2*W-1:W] : mul_product[W-1:0];
                    end
                end
            end
            ST_WB_MUL: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, latched multiply context, write-back port and flags; reset wins over any accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mulh_q    <= 1'b0;
            mul_rd_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mulh_q   <= mulh_d;
            mul_rd_q <= mul_rd_d;
            wb_rw_q  <= wr_en;
            if (wr_en) begin
                wb_rd_q   <= wr_rd;
                wb_data_q <= wr_data;
                flag_z_q  <= (wr_data == '0);
                flag_c_q  <= wr_c;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu.sv
// Directed self-checking bench for exec_alu (W = 8).
module tb_exec_alu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] rs_val = 8'h00;
    logic [7:0] rt_val = 8'h00;
    logic [2:0] rd = 3'd0;
    logic       wb_rw;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_c;

    int checks = 0;
    int errors = 0;

    exec_alu #(.W(8), .MUL_CYCLES(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .rd       (rd),
        .wb_rw    (wb_rw),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single accept edge, then drop in_valid.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] r);
        op = o; rs_val = a; rt_val = b; rd = r; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_wb(input string tag, input logic rw, input logic [2:0] r,
                            input logic [7:0] d, input logic z, input logic c);
        @(negedge clk);
        check({tag, "_rw"}, wb_rw, rw);
        check({tag, "_rd"}, wb_rd, r);
        check({tag, "_data"}, wb_data, d);
        check({tag, "_z"}, flag_z, z);
        check({tag, "_c"}, flag_c, c);
    endtask

    // Multiply op: watch in_ready and wb_rw for a bounded window; optionally keep
    // in_valid high with scrambled operands while the op is in flight.
    task automatic run_mul(input string tag, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] r, input bit jitter, input logic [7:0] exp);
        int ready_low = 0;
        int wb_at = -1;
        int wb_cnt = 0;
        logic [7:0] d = 8'h00;
        logic [2:0] wr = 3'd0;
        op = o; rs_val = a; rt_val = b; rd = r; in_valid = 1'b1;
        @(posedge clk);
        #1 if (!jitter) in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (!in_ready) ready_low++;
            else in_valid = 1'b0;
            if (wb_rw) begin
                wb_cnt++;
                if (wb_at < 0) wb_at = k;
                d  = wb_data;
                wr = wb_rd;
                in_valid = 1'b0;
            end
            if (jitter && in_valid) begin
                rs_val = 8'($urandom);
                rt_val = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        check({tag, "_busy_cycles"}, ready_low, 9);
        check({tag, "_wb_cycle"}, wb_at, 9);
        check({tag, "_wb_count"}, wb_cnt, 1);
        check({tag, "_rd"}, wr, r);
        check({tag, "_data"}, d, exp);
        check({tag, "_z"}, flag_z, (exp == 8'h00));
        check({tag, "_c"}, flag_c, 1'b0);
    endtask

    initial begin
        int wb_seen;

        // Reset with an ADD presented: it must not be accepted.
        op = 4'd0; rs_val = 8'h01; rt_val = 8'h01; rd = 3'd1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; in_valid = 1'b0;
        check_wb("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        check("reset_ready", in_ready, 1'b1);

        // ADD with carry out.
        @(posedge clk); #1;
        issue(4'd0, 8'hF0, 8'h20, 3'd3);
        check_wb("add", 1'b1, 3'd3, 8'h10, 1'b0, 1'b1);
        // Idle cycle: strobe drops, port and flags hold.
        check_wb("add_hold", 1'b0, 3'd3, 8'h10, 1'b0, 1'b1);

        // Back-to-back SUBs: zero result, then borrow.
        @(posedge clk); #1;
        op = 4'd1; rs_val = 8'h05; rt_val = 8'h05; rd = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        rs_val = 8'h03; rt_val = 8'h04;
        check_wb("sub0", 1'b1, 3'd1, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        check_wb("sub1", 1'b1, 3'd1, 8'hFF, 1'b0, 1'b1);

        // Shifts use rt[2:0]; they clear flag_c.
        @(posedge clk); #1;
        issue(4'd5, 8'h81, 8'h09, 3'd4);
        check_wb("sll", 1'b1, 3'd4, 8'h02, 1'b0, 1'b0);
        @(posedge clk); #1;
        issue(4'd6, 8'h81, 8'h07, 3'd5);
        check_wb("srl", 1'b1, 3'd5, 8'h01, 1'b0, 1'b0);

        // ADD to rd=0 would set z and c if written: nothing may change.
        @(posedge clk); #1;
        issue(4'd0, 8'h01, 8'hFF, 3'd0);
        check_wb("add_rd0", 1'b0, 3'd5, 8'h01, 1'b0, 1'b0);
        // NOP opcode with a real rd: no write either.
        @(posedge clk); #1;
        issue(4'd12, 8'h00, 8'h00, 3'd6);
        check_wb("nop", 1'b0, 3'd5, 8'h01, 1'b0, 1'b0);
        // Logic ops: XOR to zero, then OR.
        @(posedge clk); #1;
        issue(4'd4, 8'h5A, 8'h5A, 3'd2);
        check_wb("xor", 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1;
        issue(4'd3, 8'h50, 8'h0A, 3'd2);
        check_wb("or", 1'b1, 3'd2, 8'h5A, 1'b0, 1'b0);

        // Multiplies; the first keeps in_valid high with changing operands.
        run_mul("mul", 4'd8, 8'h0F, 8'h11, 3'd2, 1'b1, 8'hFF);
        run_mul("mulh_small", 4'd9, 8'h0F, 8'h11, 3'd6, 1'b0, 8'h00);
        run_mul("mulh_max", 4'd9, 8'hFF, 8'hFF, 3'd7, 1'b0, 8'hFE);

        // Reset four cycles into MUL: the op is abandoned.
        @(posedge clk); #1;
        issue(4'd8, 8'h03, 8'h05, 3'd3);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mul_ready", in_ready, 1'b1);
        check("rst_mul_data", wb_data, 8'h00);
        wb_seen = 0;
        for (int k = 0; k < 14; k++) begin
            if (wb_rw) wb_seen++;
            @(negedge clk);
        end
        check("rst_mul_no_wb", wb_seen, 0);

        // Normal ADD afterwards.
        @(posedge clk); #1;
        issue(4'd0, 8'h22, 8'h11, 3'd1);
        check_wb("add_after_rst", 1'b1, 3'd1, 8'h33, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
